// File: rtl/wishbone_manager.sv
// Single-outstanding Wishbone classic-cycle manager bridging a valid/ready request port to one arbitrator manager port.
// Optional bus timeout and saturating error counter are built when WB_MANAGER_TIMEOUT_EN is defined.
module wishbone_manager #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [3:0]           req_sel,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [31:0]          ADR_O,
    output logic [31:0]          DAT_O,
    output logic [3:0]           SEL_O,
    output logic                 WE_O,
    output logic                 STB_O,
    output logic                 CYC_O,
    input  logic [31:0]          DAT_I,
    input  logic                 ACK_I
);

    // state | meaning
    // IDLE  | no bus cycle; request port ready
    // BUS   | CYC/STB asserted, waiting for ACK_I or timeout
    typedef enum logic {IDLE, BUS} state_t;

    state_t state_q, state_d;
    logic   accept;
    logic   ack_hit;
    logic   timeout_hit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wishbone_manager: TIMEOUT_CYCLES must be 1..65535");
    end

    assign req_ready = (state_q == IDLE) && nRST;
    assign accept    = req_valid && req_ready;
    assign ack_hit   = (state_q == BUS) && ACK_I;

`ifdef WB_MANAGER_TIMEOUT_EN
    // Down-counter loaded at accept; reaching zero without ACK means the limit cycle.
    logic [15:0] to_cnt_q;

    assign timeout_hit = (state_q == BUS) && !ACK_I && (to_cnt_q == 16'd0);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            to_cnt_q <= 16'd0;
        end else if (accept) begin
            to_cnt_q <= 16'(TIMEOUT_CYCLES - 1);
        end else if (state_q == BUS && to_cnt_q != 16'd0) begin
            to_cnt_q <= to_cnt_q - 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            resp_err  <= 1'b0;
            err_count <= '0;
        end else begin
            resp_err <= timeout_hit;
            if (timeout_hit && err_count != {ERR_CNT_W{1'b1}}) begin
                err_count <= err_count + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign resp_err    = 1'b0;
    assign err_count   = '0;
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = BUS;
            BUS:     if (ack_hit || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ADR_O      <= 32'h0;
            DAT_O      <= 32'h0;
            SEL_O      <= 4'h0;
            WE_O       <= 1'b0;
            STB_O      <= 1'b0;
            CYC_O      <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            resp_valid <= ack_hit || timeout_hit;
            if (accept) begin
                ADR_O <= req_addr;
                DAT_O <= req_wdata;
                SEL_O <= req_sel;
                WE_O  <= req_write;
                STB_O <= 1'b1;
                CYC_O <= 1'b1;
            end else if (ack_hit || timeout_hit) begin
                STB_O <= 1'b0;
                CYC_O <= 1'b0;
            end
            // ACK has priority over a timeout landing in the same cycle
            if (ack_hit) begin
                resp_rdata <= WE_O ? 32'h0 : DAT_I;
            end else if (timeout_hit) begin
                resp_rdata <= 32'h0;
            end
        end
    end

endmodule
